// File: rtl/wash_panel_sequencer_pkg.sv
// Shared definitions for the wash panel sequencer: state codes, cycle modes and
// the energy-accumulation helpers.
package wash_pkg;

    localparam int ENERGY_W = 8;
    localparam int TOTAL_W  = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_CLEAN = 3'd4;
    localparam state_t ST_FAULT = 3'd5;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_QUICK  = 2'd1;
    localparam logic [1:0] MODE_HEAVY  = 2'd2;

    // Index of each edge detector in the shared rise vector.
    localparam int EDGE_START = 0;
    localparam int EDGE_CLEAN = 1;
    localparam int EDGE_MODE  = 2;
    localparam int EDGE_LOCK  = 3;
    localparam int EDGE_CMP   = 4;
    localparam int N_EDGES    = 5;

    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        return (mode == MODE_HEAVY) ? MODE_NORMAL : mode + 2'd1;
    endfunction

    function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] acc,
                                                   input logic [ENERGY_W-1:0] energy);
        logic [TOTAL_W:0] sum;
        sum = {1'b0, acc} + {{(TOTAL_W + 1 - ENERGY_W){1'b0}}, energy};
        return sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/wash_panel_sequencer_button_edge.sv
// Rising-edge detector with a registered one-cycle pulse output; a held level
// produces a single pulse.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        prev_d = level;
        rise_d = level & ~prev_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/wash_panel_sequencer.sv
// Front-panel initiator: turns button presses into machine commands, waits for
// completion and logs the energy reading of each finished run.
module wash_panel_sequencer
    import wash_pkg::*;
#(
    parameter int START_PULSE  = 2,
    parameter int RUN_TIMEOUT  = 4096,
    parameter int CLEAN_CYCLES = 64,
    parameter int COUNT_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_start,
    input  logic                btn_mode,
    input  logic                btn_lock,
    input  logic                btn_clean,
    input  logic                machine_complete,
    input  logic [ENERGY_W-1:0] machine_energy,
    output logic                start,
    output logic [1:0]          cycle_mode,
    output logic                enable_lock,
    output logic                clean_trigger,
    output logic                busy,
    output logic                timeout_err,
    output logic [COUNT_W-1:0]  run_count,
    output logic [ENERGY_W-1:0] last_energy,
    output logic [TOTAL_W-1:0]  total_energy
);

    localparam int MAX_SP  = (START_PULSE > RUN_TIMEOUT) ? START_PULSE : RUN_TIMEOUT;
    localparam int CNT_MAX = (MAX_SP > CLEAN_CYCLES) ? MAX_SP : CLEAN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // One down-counter serves all three timed states; each load ends on zero.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(START_PULSE - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CLEAN_LOAD = CNT_W'(CLEAN_CYCLES);

    logic [N_EDGES-1:0] levels;
    logic [N_EDGES-1:0] rise;

    assign levels = {machine_complete, btn_lock, btn_mode, btn_clean, btn_start};

    for (genvar gi = 0; gi < N_EDGES; gi++) begin : g_edge
        button_edge u_edge (
            .clk   (clk),
            .reset (reset),
            .level (levels[gi]),
            .rise  (rise[gi])
        );
    end

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic                 lock_req_q, lock_req_d;
    logic                 start_q, start_d;
    logic                 enable_lock_q, enable_lock_d;
    logic                 clean_trigger_q, clean_trigger_d;
    logic                 busy_q, busy_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [COUNT_W-1:0]   run_count_q, run_count_d;
    logic [ENERGY_W-1:0]  last_energy_q, last_energy_d;
    logic [TOTAL_W-1:0]   total_energy_q, total_energy_d;
    logic                 capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            mode_q          <= MODE_NORMAL;
            lock_req_q      <= 1'b0;
            start_q         <= 1'b0;
            enable_lock_q   <= 1'b0;
            clean_trigger_q <= 1'b0;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
            run_count_q     <= '0;
            last_energy_q   <= '0;
            total_energy_q  <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mode_q          <= mode_d;
            lock_req_q      <= lock_req_d;
            start_q         <= start_d;
            enable_lock_q   <= enable_lock_d;
            clean_trigger_q <= clean_trigger_d;
            busy_q          <= busy_d;
            timeout_err_q   <= timeout_err_d;
            run_count_q     <= run_count_d;
            last_energy_q   <= last_energy_d;
            total_energy_q  <= total_energy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        lock_req_d = lock_req_q;
        capture    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise[EDGE_START]) begin
                    state_d = ST_START;
                    cnt_d   = PULSE_LOAD;
                end else if (rise[EDGE_CLEAN]) begin
                    state_d = ST_CLEAN;
                    cnt_d   = CLEAN_LOAD;
                end else if (rise[EDGE_MODE]) begin
                    mode_d = next_mode(mode_q);
                end else if (rise[EDGE_LOCK]) begin
                    lock_req_d = ~lock_req_q;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = RUN_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (rise[EDGE_CMP]) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_CLEAN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_FAULT: begin
                if (rise[EDGE_START]) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        start_d         = (state_d == ST_START);
        busy_d          = (state_d != ST_IDLE);
        timeout_err_d   = (state_d == ST_FAULT);
        enable_lock_d   = lock_req_d | (state_d inside {ST_START, ST_RUN, ST_FAULT});
        clean_trigger_d = (state_d == ST_CLEAN) && (state_q != ST_CLEAN);
        run_count_d     = run_count_q;
        last_energy_d   = last_energy_q;
        total_energy_d  = total_energy_q;
        if (capture) begin
            run_count_d    = run_count_q + 1'b1;
            last_energy_d  = machine_energy;
            total_energy_d = sat_add(total_energy_q, machine_energy);
        end
    end

    assign start         = start_q;
    assign cycle_mode    = mode_q;
    assign enable_lock   = enable_lock_q;
    assign clean_trigger = clean_trigger_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign run_count     = run_count_q;
    assign last_energy   = last_energy_q;
    assign total_energy  = total_energy_q;

endmodule
